// File: rtl/exp_sram_arbiter_if.sv
// Request/response bus shared by the CPU port, the audio fetcher, the
// arbiter and the expansion SRAM pins.
// The arbiter connects through the slave modport; the core-side requesters
// and the SRAM pin logic use the master modport.
interface exp_sram_arbiter_if;
    // CPU expansion-memory port
    logic        cpu_req;
    logic        cpu_we;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    // wavuno sample fetcher (read-only)
    logic        aud_req;
    logic [20:0] aud_addr;
    logic [7:0]  aud_rdata;
    logic        aud_ack;
    // expansion SRAM pins
    logic [20:0] exp_sram_addr;
    logic [7:0]  exp_sram_data_o;
    logic        exp_sram_data_oe;
    logic [7:0]  exp_sram_data_i;
    logic        exp_sram_we_n;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  aud_req, aud_addr,
        input  exp_sram_data_i,
        output cpu_rdata, cpu_ack, aud_rdata, aud_ack,
        output exp_sram_addr, exp_sram_data_o, exp_sram_data_oe, exp_sram_we_n
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output aud_req, aud_addr,
        output exp_sram_data_i,
        input  cpu_rdata, cpu_ack, aud_rdata, aud_ack,
        input  exp_sram_addr, exp_sram_data_o, exp_sram_data_oe, exp_sram_we_n
    );
endinterface

// File: rtl/exp_sram_arbiter.sv
// Expansion SRAM arbiter: shares one asynchronous 2M x 8 SRAM between the
// Z80 expansion port and the wavuno audio fetcher, sequencing read and write
// cycles on the 28 MHz clock. All SRAM pins are registered.
// Optional build macro EXP_SRAM_STATS_EN adds the stats_clr input and the
// aud_wait_max output (worst audio request-to-ack wait, saturating at 255).
module exp_sram_arbiter #(
    parameter int unsigned RD_CYCLES = 2,  // 1..7 clocks of address before sampling
    parameter int unsigned WR_CYCLES = 2   // 1..7 clocks of we_n low
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef EXP_SRAM_STATS_EN
    input  logic               stats_clr,
    output logic [7:0]         aud_wait_max,
`endif
    exp_sram_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    localparam logic [2:0] RD_LAST = 3'(RD_CYCLES - 1);
    localparam logic [2:0] WR_LAST = 3'(WR_CYCLES - 1);

    state_t     state;
    logic [2:0] cnt;       // clocks remaining in READ / WR_PULSE
    logic       gnt_aud;   // current access belongs to the audio fetcher
    logic       last_aud;  // previous grant went to audio

    // Arbitration and SRAM cycle sequencing; every pin and ack is registered.
    // NOTE: clocked state uses non-blocking assignments only, so every branch
    // sees the pre-edge values and the outputs stay glitch-free registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            cnt                  <= '0;
            gnt_aud              <= 1'b0;
            last_aud             <= 1'b0;
            bus.exp_sram_addr    <= '0;
            bus.exp_sram_data_o  <= '0;
            bus.exp_sram_data_oe <= 1'b0;
            bus.exp_sram_we_n    <= 1'b1;
            bus.cpu_ack          <= 1'b0;
            bus.aud_ack          <= 1'b0;
            bus.cpu_rdata        <= '0;
            bus.aud_rdata        <= '0;
        end else begin
            // NOTE: acks default low every clock so a single set below yields
            // exactly a one-cycle pulse.
            bus.cpu_ack <= 1'b0;
            bus.aud_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Turnaround clock: bus released before any new grant.
                    bus.exp_sram_we_n    <= 1'b1;
                    bus.exp_sram_data_oe <= 1'b0;
                    if (bus.aud_req && (!bus.cpu_req || !last_aud)) begin
                        gnt_aud           <= 1'b1;
                        last_aud          <= 1'b1;
                        bus.exp_sram_addr <= bus.aud_addr;
                        cnt               <= RD_LAST;
                        state             <= S_READ;
                    end else if (bus.cpu_req) begin
                        gnt_aud             <= 1'b0;
                        last_aud            <= 1'b0;
                        bus.exp_sram_addr   <= bus.cpu_addr;
                        bus.exp_sram_data_o <= bus.cpu_wdata;
                        if (bus.cpu_we) begin
                            bus.exp_sram_data_oe <= 1'b1;
                            state                <= S_WR_SETUP;
                        end else begin
                            cnt   <= RD_LAST;
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (cnt == '0) begin
                        if (gnt_aud) begin
                            bus.aud_rdata <= bus.exp_sram_data_i;
                            bus.aud_ack   <= 1'b1;
                        end else begin
                            bus.cpu_rdata <= bus.exp_sram_data_i;
                            bus.cpu_ack   <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_WR_SETUP: begin
                    bus.exp_sram_we_n <= 1'b0;
                    cnt               <= WR_LAST;
                    state             <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (cnt == '0) begin
                        bus.exp_sram_we_n <= 1'b1;
                        state             <= S_WR_HOLD;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_WR_HOLD: begin
                    bus.cpu_ack          <= 1'b1;
                    bus.exp_sram_data_oe <= 1'b0;
                    state                <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef EXP_SRAM_STATS_EN
    logic [7:0] aud_wait_cnt;  // clocks the current audio request has waited
    logic       aud_done;
    logic [8:0] aud_wait_now;
    logic [7:0] aud_wait_sat;

    assign aud_done     = (state == S_READ) && (cnt == '0) && gnt_aud;
    assign aud_wait_now = {1'b0, aud_wait_cnt} + 9'd1;
    assign aud_wait_sat = aud_wait_now[8] ? 8'hFF : aud_wait_now[7:0];

    // Track the worst audio wait from req rising to ack, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aud_wait_cnt <= '0;
            aud_wait_max <= '0;
        end else begin
            if (!bus.aud_req || aud_done) begin
                aud_wait_cnt <= '0;
            end else if (aud_wait_cnt != 8'hFF) begin
                aud_wait_cnt <= aud_wait_cnt + 8'd1;
            end
            if (stats_clr) begin
                aud_wait_max <= '0;
            end else if (aud_done && (aud_wait_sat > aud_wait_max)) begin
                aud_wait_max <= aud_wait_sat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exp_sram_arbiter.sv
// Self-checking bench for exp_sram_arbiter: directed vector table, write
// waveform, mid-write reset, arbitration fairness, back-to-back audio and a
// randomized run against a transaction-level model with its own SRAM image.
`timescale 1ns/1ps
module tb_exp_sram_arbiter;

    localparam int RD = 2;
    localparam int WR = 2;
    localparam logic [20:0] BASE = 21'h1FFFF0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef EXP_SRAM_STATS_EN
    logic       stats_clr = 1'b0;
    logic [7:0] aud_wait_max;
`endif

    exp_sram_arbiter_if bus ();

    exp_sram_arbiter #(.RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef EXP_SRAM_STATS_EN
        .stats_clr    (stats_clr),
        .aud_wait_max (aud_wait_max),
`endif
        .bus          (bus)
    );

    always #18 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- pin-level asynchronous SRAM model ----------------
    logic [7:0] sram [bit [20:0]];

    function automatic logic [7:0] sram_rd(input logic [20:0] a);
        if (sram.exists(a)) return sram[a];
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
    endfunction

    logic        wr_low_q = 1'b0;
    logic [20:0] wr_addr_q;
    logic [7:0]  wr_data_q;

    // Writes land while we_n is low; address, data and oe must hold steady.
    always @(negedge clk) begin
        if (bus.exp_sram_we_n === 1'b0) begin
            check("bus_oe_during_we", bus.exp_sram_data_oe, 1'b1);
            if (wr_low_q) begin
                check("bus_addr_stable", bus.exp_sram_addr, wr_addr_q);
                check("bus_data_stable", bus.exp_sram_data_o, wr_data_q);
            end
            sram[bus.exp_sram_addr] = bus.exp_sram_data_o;
            wr_low_q  = 1'b1;
            wr_addr_q = bus.exp_sram_addr;
            wr_data_q = bus.exp_sram_data_o;
        end else begin
            wr_low_q = 1'b0;
        end
        bus.exp_sram_data_i = sram_rd(bus.exp_sram_addr);
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          is_aud;
        bit          we;
        logic [20:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        int          exp_lat;   // clocks from driving req to seeing ack
    } vec_t;

    vec_t tbl [12];

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        bus.aud_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated transaction: latency, data, ack exclusivity, oe on reads.
    task automatic run_one(input vec_t v, input string tag);
        int t0;
        int lat;
        logic wrong;
        logic oe_rd;
        logic [7:0] rd;
        @(negedge clk);
        t0 = cyc;
        lat = -1;
        wrong = 1'b0;
        oe_rd = 1'b0;
        rd = '0;
        if (v.is_aud) begin
            bus.aud_req = 1'b1;
            bus.aud_addr = v.addr;
        end else begin
            bus.cpu_req = 1'b1;
            bus.cpu_we = v.we;
            bus.cpu_addr = v.addr;
            bus.cpu_wdata = v.wdata;
        end
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (v.is_aud ? bus.cpu_ack : bus.aud_ack) wrong = 1'b1;
            if (!v.we && bus.exp_sram_data_oe) oe_rd = 1'b1;
            if (v.is_aud ? bus.aud_ack : bus.cpu_ack) begin
                lat = cyc - t0;
                rd = v.is_aud ? bus.aud_rdata : bus.cpu_rdata;
                bus.aud_req = 1'b0;
                bus.cpu_req = 1'b0;
            end
        end
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_other_ack"}, wrong, 1'b0);
        if (!v.we) begin
            check({tag, "_rdata"}, rd, v.exp_rdata);
            check({tag, "_oe_in_read"}, oe_rd, 1'b0);
        end
        @(negedge clk);
        check({tag, "_ack_pulse_width"}, bus.cpu_ack | bus.aud_ack, 1'b0);
    endtask

    // ---------------- randomized run state ----------------
    logic [7:0]  tmem [bit [20:0]];   // transaction-level memory image
    logic        c_busy, a_busy, c_we;
    logic [20:0] c_addr, a_addr;
    logic [7:0]  c_wd, m_data, pre;
    logic        m_pend, m_aud, m_last_aud, e_cpu, e_aud;
    int          m_ack_at, a_start, wmax, wt, n;

    // scratch for hand sequences
    logic [20:0] v_addr;
    logic        ack_seen, cpu_seen, turn_aud, done;
    int          prev, cnt;
    logic        exp_we [5];
    logic        exp_oe [5];
    logic        exp_ack [5];

    initial begin
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        bus.aud_req = 1'b0;
        bus.aud_addr = '0;

        sram[21'h00010]  = 8'h3C;
        sram[21'h1FFFFF] = 8'hC3;
        sram[21'h00000]  = 8'h77;

        tbl[0]  = '{1'b0, 1'b1, 21'h12345,  8'hA5, 8'h00, 5};
        tbl[1]  = '{1'b0, 1'b0, 21'h12345,  8'h00, 8'hA5, 3};
        tbl[2]  = '{1'b0, 1'b0, 21'h00010,  8'h00, 8'h3C, 3};
        tbl[3]  = '{1'b1, 1'b0, 21'h12345,  8'h00, 8'hA5, 3};
        tbl[4]  = '{1'b1, 1'b0, 21'h1FFFFF, 8'h00, 8'hC3, 3};
        tbl[5]  = '{1'b0, 1'b1, 21'h00000,  8'h00, 8'h00, 5};
        tbl[6]  = '{1'b0, 1'b0, 21'h00000,  8'h00, 8'h00, 3};
        tbl[7]  = '{1'b0, 1'b1, 21'h1FFFFF, 8'hFF, 8'h00, 5};
        tbl[8]  = '{1'b1, 1'b0, 21'h1FFFFF, 8'h00, 8'hFF, 3};
        tbl[9]  = '{1'b0, 1'b1, 21'h0ABCD,  8'h5A, 8'h00, 5};
        tbl[10] = '{1'b1, 1'b0, 21'h0ABCD,  8'h00, 8'h5A, 3};
        tbl[11] = '{1'b0, 1'b0, 21'h0ABCD,  8'h00, 8'h5A, 3};

        // ---- reset values (clock running with rst_n low) ----
        repeat (2) @(negedge clk);
        check("rst_we_n", bus.exp_sram_we_n, 1'b1);
        check("rst_oe", bus.exp_sram_data_oe, 1'b0);
        check("rst_addr", bus.exp_sram_addr, 21'h0);
        check("rst_data_o", bus.exp_sram_data_o, 8'h00);
        check("rst_cpu_ack", bus.cpu_ack, 1'b0);
        check("rst_aud_ack", bus.aud_ack, 1'b0);
        check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        check("rst_aud_rdata", bus.aud_rdata, 8'h00);
`ifdef EXP_SRAM_STATS_EN
        check("rst_wait_max", aud_wait_max, 8'h00);
`endif
        rst_n = 1'b1;

        // ---- vector table ----
        for (int i = 0; i < 12; i++) run_one(tbl[i], $sformatf("vec%0d", i));

        // ---- CPU write waveform: 0xA5 -> 0x12345 ----
        exp_we  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_oe  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_ack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 21'h12345;
        bus.cpu_wdata = 8'hA5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("wr_we_n_clk%0d", k), bus.exp_sram_we_n, exp_we[k]);
            check($sformatf("wr_oe_clk%0d", k), bus.exp_sram_data_oe, exp_oe[k]);
            check($sformatf("wr_ack_clk%0d", k), bus.cpu_ack, exp_ack[k]);
            if (exp_oe[k]) begin
                check($sformatf("wr_addr_clk%0d", k), bus.exp_sram_addr, 21'h12345);
                check($sformatf("wr_data_clk%0d", k), bus.exp_sram_data_o, 8'hA5);
            end
            if (bus.cpu_ack) bus.cpu_req = 1'b0;
        end
        bus.cpu_req = 1'b0;
        check("wr_sram_content", sram_rd(21'h12345), 8'hA5);

        // ---- reset in first clock of WR_PULSE ----
        sram[21'h00777] = 8'h11;
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 21'h00777;
        bus.cpu_wdata = 8'hEE;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rstw_we_low_before", bus.exp_sram_we_n, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rstw_we_n_async", bus.exp_sram_we_n, 1'b1);
        check("rstw_oe_async", bus.exp_sram_data_oe, 1'b0);
        check("rstw_addr_async", bus.exp_sram_addr, 21'h0);
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.aud_ack) ack_seen = 1'b1;
        end
        check("rstw_no_ack", ack_seen, 1'b0);
        check("rstw_no_partial_write", sram_rd(21'h00777), 8'h11);
        run_one('{1'b0, 1'b0, 21'h00777, 8'h00, 8'h11, 3}, "rstw_readback");

        // ---- both requesters from reset: audio first, then strict alternation ----
        apply_reset();
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 21'h12345;
        bus.aud_req = 1'b1;
        bus.aud_addr = 21'h0ABCD;
        turn_aud = 1'b1;
        prev = cyc;
        cnt = 0;
        for (int k = 0; k < 80 && cnt < 10; k++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.aud_ack) begin
                check($sformatf("alt_who_%0d", cnt), bus.aud_ack, turn_aud);
                check($sformatf("alt_excl_%0d", cnt), bus.cpu_ack & bus.aud_ack, 1'b0);
                check($sformatf("alt_data_%0d", cnt),
                      bus.aud_ack ? bus.aud_rdata : bus.cpu_rdata,
                      turn_aud ? 8'h5A : 8'hA5);
                check($sformatf("alt_gap_%0d", cnt), cyc - prev, 3);
                prev = cyc;
                turn_aud = !turn_aud;
                cnt++;
            end
        end
        bus.cpu_req = 1'b0;
        bus.aud_req = 1'b0;
        check("alt_count", cnt, 10);
        @(negedge clk);

        // ---- audio held continuously, CPU idle: ack every 3 clocks ----
        @(negedge clk);
        bus.aud_req = 1'b1;
        bus.aud_addr = 21'h1FFFFF;
        prev = cyc;
        cnt = 0;
        cpu_seen = 1'b0;
        for (int k = 0; k < 40 && cnt < 5; k++) begin
            @(negedge clk);
            if (bus.cpu_ack) cpu_seen = 1'b1;
            if (bus.aud_ack) begin
                check($sformatf("b2b_gap_%0d", cnt), cyc - prev, 3);
                check($sformatf("b2b_data_%0d", cnt), bus.aud_rdata, 8'hFF);
                prev = cyc;
                cnt++;
            end
        end
        bus.aud_req = 1'b0;
        check("b2b_count", cnt, 5);
        check("b2b_no_cpu_ack", cpu_seen, 1'b0);

        // ---- randomized traffic against transaction-level model ----
        apply_reset();
        for (int a = 0; a < 16; a++) begin
            v_addr = BASE | 21'(a);
            pre = 8'($urandom);
            sram[v_addr] = pre;
            tmem[v_addr] = pre;
        end
        c_busy = 1'b0; a_busy = 1'b0; c_we = 1'b0;
        m_pend = 1'b0; m_aud = 1'b0; m_last_aud = 1'b0;
        m_ack_at = 0; a_start = 0; wmax = 0; m_data = '0;
        c_addr = BASE; a_addr = BASE; c_wd = '0;
        for (int i = 0; i < 3300; i++) begin
            @(negedge clk);
            n = cyc;
            e_cpu = m_pend && (m_ack_at == n) && !m_aud;
            e_aud = m_pend && (m_ack_at == n) && m_aud;
            check("rnd_cpu_ack", bus.cpu_ack, e_cpu);
            check("rnd_aud_ack", bus.aud_ack, e_aud);
            if (e_cpu) begin
                if (!c_we) check("rnd_cpu_rdata", bus.cpu_rdata, m_data);
                c_busy = 1'b0;
                bus.cpu_req = 1'b0;
                m_pend = 1'b0;
            end
            if (e_aud) begin
                check("rnd_aud_rdata", bus.aud_rdata, m_data);
                a_busy = 1'b0;
                bus.aud_req = 1'b0;
                m_pend = 1'b0;
                wt = n - a_start;
                if (wt > 255) wt = 255;
                if (wt > wmax) wmax = wt;
            end
            if (i < 3000) begin
                if (!c_busy && $urandom_range(0, 2) == 0) begin
                    c_busy = 1'b1;
                    c_we = 1'($urandom_range(0, 1));
                    c_addr = BASE | 21'($urandom_range(0, 15));
                    c_wd = 8'($urandom);
                    bus.cpu_req = 1'b1;
                    bus.cpu_we = c_we;
                    bus.cpu_addr = c_addr;
                    bus.cpu_wdata = c_wd;
                end
                if (!a_busy && $urandom_range(0, 2) == 0) begin
                    a_busy = 1'b1;
                    a_addr = BASE | 21'($urandom_range(0, 15));
                    a_start = n;
                    bus.aud_req = 1'b1;
                    bus.aud_addr = a_addr;
                end
            end
            // Next edge: a free arbiter serves whoever is waiting; audio wins a
            // tie unless audio had the previous grant.
            if (!m_pend && (c_busy || a_busy)) begin
                m_aud = a_busy && (!c_busy || !m_last_aud);
                m_last_aud = m_aud;
                m_pend = 1'b1;
                if (m_aud) begin
                    m_data = tmem[a_addr];
                    m_ack_at = n + 1 + RD;
                end else if (c_we) begin
                    tmem[c_addr] = c_wd;
                    m_ack_at = n + 1 + WR + 2;
                end else begin
                    m_data = tmem[c_addr];
                    m_ack_at = n + 1 + RD;
                end
            end
        end
        check("rnd_drained", m_pend | c_busy | a_busy, 1'b0);

`ifdef EXP_SRAM_STATS_EN
        // ---- wait statistics ----
        check("stats_rnd_max", aud_wait_max, 8'(wmax));
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        check("stats_clr_rnd", aud_wait_max, 8'h00);
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 21'h00200;
        bus.cpu_wdata = 8'h42;
        @(negedge clk);
        bus.aud_req = 1'b1;
        bus.aud_addr = 21'h12345;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (bus.cpu_ack) bus.cpu_req = 1'b0;
            if (bus.aud_ack) begin
                bus.aud_req = 1'b0;
                done = 1'b1;
            end
        end
        check("stats_aud_done", done, 1'b1);
        check("stats_wait_during_write", aud_wait_max, 8'd7);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        check("stats_clr", aud_wait_max, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
